// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM 4:1 link: slot indices and lock FSM encoding.
package tdm_pkg;
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/tdm_slot_dec.sv
// Slot decoder: turns a slot index plus write enable into a one-hot lane enable.
module tdm_slot_dec (
  input  logic [1:0] sel,
  input  logic       wr_en,
  output logic [3:0] slot_en
);
  always_comb begin
    slot_en = '0;
    if (wr_en) slot_en[sel] = 1'b1;
  end
endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: locks onto frame_sync, de-interleaves slots into shadow
// registers and publishes all four lanes together once a frame is complete.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [CNT_W-1:0] frame_cnt
);
  state_t                 state_q, state_d;
  logic [1:0]             sel_q, sel_d, wr_sel;
  logic                   wr_en, err;
  logic [3:0]             slot_en;
  logic [2:0][WIDTH-1:0]  shadow_q;
  logic [3:0][WIDTH-1:0]  lane_q;
  logic                   fv_q, err_q;
  logic [CNT_W-1:0]       cnt_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wr_sel  = sel_q;
    wr_en   = 1'b0;
    err     = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: if (frame_sync) begin
          wr_en   = 1'b1;
          wr_sel  = SLOT_A;
          sel_d   = SLOT_B;
          state_d = RUN;
        end
        RUN: begin
          if (frame_sync) begin
            // a sync mid-frame restarts the frame at slot 0
            err    = (sel_q != SLOT_A);
            wr_en  = 1'b1;
            wr_sel = SLOT_A;
            sel_d  = SLOT_B;
          end else if (sel_q == SLOT_A) begin
            err     = 1'b1;
            state_d = HUNT;
            sel_d   = SLOT_A;
          end else begin
            wr_en = 1'b1;
            sel_d = (sel_q == SLOT_D) ? SLOT_A : sel_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  tdm_slot_dec u_dec (.sel(wr_sel), .wr_en(wr_en), .slot_en(slot_en));

  // slot-3 enable doubles as the publish strobe; d comes straight from din
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      sel_q    <= SLOT_A;
      shadow_q <= '0;
      lane_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fv_q    <= slot_en[3];
      err_q   <= err;
      for (int i = 0; i < 3; i++)
        if (slot_en[i]) shadow_q[i] <= din;
      if (slot_en[3]) begin
        lane_q <= {din, shadow_q[2], shadow_q[1], shadow_q[0]};
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign a           = lane_q[0];
  assign b           = lane_q[1];
  assign c           = lane_q[2];
  assign d           = lane_q[3];
  assign sel         = sel_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == RUN);
  assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: table vectors, directed corner cases and random beats
// against a queue-based frame model; a narrow CNT_W=2 copy covers counter wrap.
module tb_tdm_demux_1x4;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0, frame_sync = 1'b0;

  logic [3:0] a, b, c, d;
  logic [1:0] sel;
  logic       frame_valid, sync_err, locked;
  logic [7:0] frame_cnt;

  logic       a1, b1, c1, d1, fv1, err1, lk1;
  logic [1:0] sel1, cnt1;

  int total = 0, bad = 0;

  tdm_demux_1x4 #(.WIDTH(4), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(a), .b(b), .c(c), .d(d), .sel(sel), .frame_valid(frame_valid),
    .sync_err(sync_err), .locked(locked), .frame_cnt(frame_cnt));

  tdm_demux_1x4 #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel1), .frame_valid(fv1),
    .sync_err(err1), .locked(lk1), .frame_cnt(cnt1));

  always #5 clk = ~clk;

  // reference model: a frame is the list of samples collected since the last sync
  logic [3:0] frm[$];
  bit         m_lock;
  logic [3:0] ma, mb, mc, md;
  int         mcnt;
  bit         mfv, merr;

  task automatic model_reset();
    frm.delete(); m_lock = 0; ma = 0; mb = 0; mc = 0; md = 0; mcnt = 0; mfv = 0; merr = 0;
  endtask

  task automatic model_beat(input bit v, input bit s, input logic [3:0] x);
    mfv = 0; merr = 0;
    if (!v) return;
    if (!m_lock) begin
      if (s) begin frm.delete(); frm.push_back(x); m_lock = 1; end
    end else if (s) begin
      if (frm.size() != 0) merr = 1;
      frm.delete(); frm.push_back(x);
    end else if (frm.size() == 0) begin
      merr = 1; m_lock = 0;
    end else begin
      frm.push_back(x);
      if (frm.size() == 4) begin
        ma = frm[0]; mb = frm[1]; mc = frm[2]; md = frm[3];
        mcnt++; mfv = 1; frm.delete();
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all();
    chk("a", a, ma); chk("b", b, mb); chk("c", c, mc); chk("d", d, md);
    chk("sel", sel, frm.size()); chk("frame_valid", frame_valid, mfv);
    chk("sync_err", sync_err, merr); chk("locked", locked, m_lock);
    chk("frame_cnt", frame_cnt, mcnt % 256);
    chk("n_a", a1, ma[0]); chk("n_b", b1, mb[0]); chk("n_c", c1, mc[0]); chk("n_d", d1, md[0]);
    chk("n_sel", sel1, frm.size()); chk("n_fv", fv1, mfv); chk("n_err", err1, merr);
    chk("n_locked", lk1, m_lock); chk("n_cnt", cnt1, mcnt % 4);
  endtask

  task automatic step(input bit v, input bit s, input logic [3:0] x);
    din_valid = v; frame_sync = s; din = x;
    @(posedge clk); #1;
    model_beat(v, s, x);
    chk_all();
  endtask

  task automatic do_reset();
    rst_n = 0; din_valid = 0; frame_sync = 0;
    @(posedge clk); #1;
    model_reset();
    chk_all();
    rst_n = 1;
  endtask

  task automatic frame(input logic [3:0] w, x, y, z);
    step(1, 1, w); step(1, 0, x); step(1, 0, y); step(1, 0, z);
  endtask

  typedef struct {
    bit v, s; logic [3:0] din;
    logic [3:0] ea, eb, ec, ed; logic [1:0] esel; bit efv, eerr, elk; int ecnt;
  } vec_t;
  vec_t tv[11];

  function automatic vec_t mk(bit v, bit s, logic [3:0] x, logic [15:0] eabcd,
                              logic [1:0] es, bit efv, bit eer, bit elk, int ec);
    vec_t t;
    t.v = v; t.s = s; t.din = x;
    {t.ea, t.eb, t.ec, t.ed} = eabcd;
    t.esel = es; t.efv = efv; t.eerr = eer; t.elk = elk; t.ecnt = ec;
    return t;
  endfunction

  task automatic apply_vec(input int i);
    step(tv[i].v, tv[i].s, tv[i].din);
    chk("t_abcd", {a, b, c, d}, {tv[i].ea, tv[i].eb, tv[i].ec, tv[i].ed});
    chk("t_sel", sel, tv[i].esel); chk("t_fv", frame_valid, tv[i].efv);
    chk("t_err", sync_err, tv[i].eerr); chk("t_lock", locked, tv[i].elk);
    chk("t_cnt", frame_cnt, tv[i].ecnt);
  endtask

  int fv_seen;

  initial begin
    // scenario 1: single frame 0,1,0,1
    tv[0]  = mk(1, 1, 4'h0, 16'h0000, 2'd1, 0, 0, 1, 0);
    tv[1]  = mk(1, 0, 4'h1, 16'h0000, 2'd2, 0, 0, 1, 0);
    tv[2]  = mk(1, 0, 4'h0, 16'h0000, 2'd3, 0, 0, 1, 0);
    tv[3]  = mk(1, 0, 4'h1, 16'h0101, 2'd0, 1, 0, 1, 1);
    // scenario 2 (after reset): hunt filtering then a frame
    tv[4]  = mk(1, 0, 4'hF, 16'h0000, 2'd0, 0, 0, 0, 0);
    tv[5]  = mk(1, 0, 4'hF, 16'h0000, 2'd0, 0, 0, 0, 0);
    tv[6]  = mk(1, 0, 4'hF, 16'h0000, 2'd0, 0, 0, 0, 0);
    tv[7]  = mk(1, 1, 4'h3, 16'h0000, 2'd1, 0, 0, 1, 0);
    tv[8]  = mk(1, 0, 4'h5, 16'h0000, 2'd2, 0, 0, 1, 0);
    tv[9]  = mk(1, 0, 4'h9, 16'h0000, 2'd3, 0, 0, 1, 0);
    tv[10] = mk(1, 0, 4'hC, 16'h359C, 2'd0, 1, 0, 1, 1);

    model_reset();
    #2; chk("rst_locked", locked, 0); chk("rst_cnt", frame_cnt, 0);
    do_reset();
    for (int i = 0; i < 4; i++) apply_vec(i);
    step(0, 0, 0);
    chk("fv_single_pulse", frame_valid, 0);
    do_reset();
    for (int i = 4; i < 11; i++) apply_vec(i);

    // scenario 3: early sync at sel=2
    step(1, 1, 4'h1); step(1, 0, 4'h2);
    step(1, 1, 4'h7);
    chk("early_err", sync_err, 1); chk("early_nofv", frame_valid, 0);
    chk("early_sel", sel, 1); chk("early_a_hold", a, 4'h3);
    step(1, 0, 4'h4); step(1, 0, 4'h5); step(1, 0, 4'h6);
    chk("early_pub", {a, b, c, d}, 16'h7456);

    // scenario 4: lost sync after a full frame
    frame(4'hA, 4'hB, 4'hC, 4'hD);
    step(1, 0, 4'h8);
    chk("lost_err", sync_err, 1); chk("lost_lock", locked, 0);
    chk("lost_hold", {a, b, c, d}, 16'hABCD);

    // scenario 5: gapped frame, then back-to-back frames
    do_reset();
    step(1, 1, 4'h0); step(0, 0, 4'hF); step(0, 1, 4'hF);
    step(1, 0, 4'h1); step(0, 0, 4'hF); step(0, 0, 4'hF);
    step(1, 0, 4'h0); step(0, 1, 4'hF); step(0, 0, 4'hF);
    step(1, 0, 4'h1);
    chk("gap_pub", {a, b, c, d}, 16'h0101);
    fv_seen = 0;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 4; k++) begin
        step(1, k == 0, 4'(f * 4 + k));
        if (frame_valid) fv_seen++;
        if (k != 3) chk("b2b_no_fv", frame_valid, 0);
      end
    chk("b2b_fv_count", fv_seen, 4); chk("b2b_cnt", frame_cnt, 5);
    chk("b2b_last", {a, b, c, d}, 16'hCDEF);

    // scenario 6: async reset mid-frame, then counter wrap on narrow copy
    step(1, 1, 4'h2); step(1, 0, 4'h3);
    #2 rst_n = 0; #1;
    chk("async_abcd", {a, b, c, d}, 0); chk("async_sel", sel, 0);
    chk("async_lock", locked, 0); chk("async_cnt", frame_cnt, 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    step(1, 0, 4'h9);
    chk("post_rst_hunt", locked, 0);
    frame(4'h6, 4'h7, 4'h8, 4'h9);
    chk("post_rst_pub", {a, b, c, d}, 16'h6789);
    for (int f = 0; f < 3; f++) frame(4'h1, 4'h0, 4'h1, 4'h0);
    chk("wrap_cnt_narrow", cnt1, 0); chk("wrap_cnt_wide", frame_cnt, 4);

    // random beats, mostly well-formed with occasional misplaced sync
    for (int n = 0; n < 3000; n++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = (frm.size() == 0) && m_lock;
      if (!m_lock) s = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) s = !s;
      step(v, s, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
